// File: rtl/fw_scan_chain_ctrl_if.sv
// -----------------------------------------------------------------------------
// fw_scan_chain_ctrl_if
// Bundles the control/status word interface and the serial scan pins of one
// firmware scan-chain slot.
//   master : firmware / bench side. Drives the configuration and the start
//            pulse, and returns the DUT's serial response on fw_scan_out.
//   slave  : fw_scan_chain_ctrl. Drives the status, the captured word and the
//            bxclk / scan_in / scan_load pins.
// Optional macro FW_SCAN_LOOPBACK_EN adds cfg_loopback (master -> slave).
// -----------------------------------------------------------------------------
interface fw_scan_chain_ctrl_if #(
  parameter int SCAN_LEN   = 768,
  parameter int HALF_PER_W = 8
);
  logic                  cfg_start;
  logic [HALF_PER_W-1:0] cfg_half_period;
  logic [SCAN_LEN-1:0]   scan_data_in;
  logic [SCAN_LEN-1:0]   scan_data_out;
  logic                  busy;
  logic                  done;
  logic                  fw_bxclk;
  logic                  fw_scan_in;
  logic                  fw_scan_load;
  logic                  fw_scan_out;
`ifdef FW_SCAN_LOOPBACK_EN
  logic                  cfg_loopback;

  modport master (
    output cfg_start, cfg_half_period, scan_data_in, fw_scan_out, cfg_loopback,
    input  scan_data_out, busy, done, fw_bxclk, fw_scan_in, fw_scan_load
  );
  modport slave (
    input  cfg_start, cfg_half_period, scan_data_in, fw_scan_out, cfg_loopback,
    output scan_data_out, busy, done, fw_bxclk, fw_scan_in, fw_scan_load
  );
`else
  modport master (
    output cfg_start, cfg_half_period, scan_data_in, fw_scan_out,
    input  scan_data_out, busy, done, fw_bxclk, fw_scan_in, fw_scan_load
  );
  modport slave (
    input  cfg_start, cfg_half_period, scan_data_in, fw_scan_out,
    output scan_data_out, busy, done, fw_bxclk, fw_scan_in, fw_scan_load
  );
`endif
endinterface

// File: rtl/fw_scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// fw_scan_chain_ctrl
// Firmware-side scan-chain sequencer. On a start pulse it latches the half
// period H and the word to send, pulses fw_scan_load for one bxclk period,
// then shifts SCAN_LEN bits out on fw_scan_in (MSB first, changed on bxclk
// falling ticks) while capturing fw_scan_out on rising ticks. The captured
// word is published on scan_data_out together with a one-cycle done pulse.
//
// Ports
//   fw_pl_clk1 : clock, all logic on the rising edge
//   fw_rst_n   : asynchronous active-low reset
//   bus        : fw_scan_chain_ctrl_if.slave (cfg_start, cfg_half_period,
//                scan_data_in, scan_data_out, busy, done, fw_bxclk,
//                fw_scan_in, fw_scan_load, fw_scan_out[, cfg_loopback])
//
// Optional macro FW_SCAN_LOOPBACK_EN: adds cfg_loopback; when set, the
// rising-tick capture samples our own fw_scan_in instead of fw_scan_out.
// -----------------------------------------------------------------------------
module fw_scan_chain_ctrl #(
  parameter int SCAN_LEN   = 768,
  parameter int HALF_PER_W = 8
) (
  input  logic                  fw_pl_clk1,
  input  logic                  fw_rst_n,
  fw_scan_chain_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(SCAN_LEN + 1);
  localparam logic [CNT_W-1:0]      BIT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      BIT_LAST = CNT_W'(SCAN_LEN - 1);
  localparam logic [HALF_PER_W-1:0] DIV_ONE  = HALF_PER_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e                state_q,    state_d;
  logic [HALF_PER_W-1:0] div_cnt_q,  div_cnt_d;
  logic [HALF_PER_W-1:0] half_q,     half_d;
  logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [SCAN_LEN-1:0]   tx_q,       tx_d;
  logic [SCAN_LEN-1:0]   rx_q,       rx_d;
  logic [SCAN_LEN-1:0]   data_out_q, data_out_d;
  logic                  bxclk_q,    bxclk_d;
  logic                  scan_in_q,  scan_in_d;
  logic                  load_q,     load_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  logic tick;
  logic sample;

  // Divider terminal count; half_q is never 0 outside IDLE, so H-1 cannot wrap
  // while the counter is running.
  assign tick = (div_cnt_q == (half_q - DIV_ONE));

`ifdef FW_SCAN_LOOPBACK_EN
  assign sample = bus.cfg_loopback ? scan_in_q : bus.fw_scan_out;
`else
  assign sample = bus.fw_scan_out;
`endif

  // NOTE: every _d gets a default at the top of the block, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    half_d     = half_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    bxclk_d    = bxclk_q;
    scan_in_d  = scan_in_q;
    load_d     = load_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      div_cnt_d = tick ? '0 : (div_cnt_q + DIV_ONE);
    end

    case (state_q)
      IDLE: begin
        bxclk_d   = 1'b0;
        load_d    = 1'b0;
        scan_in_d = 1'b0;
        if (bus.cfg_start) begin
          half_d    = (bus.cfg_half_period == '0) ? DIV_ONE : bus.cfg_half_period;
          tx_d      = bus.scan_data_in;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          load_d    = 1'b1;
          busy_d    = 1'b1;
          state_d   = LOAD;
        end
      end

      // One full bxclk period with the load strobe high; the first data bit is
      // presented on the falling tick that ends it.
      LOAD: begin
        if (tick) begin
          bxclk_d = ~bxclk_q;
          if (bxclk_q) begin
            load_d    = 1'b0;
            scan_in_d = tx_q[SCAN_LEN-1];
            state_d   = SHIFT;
          end
        end
      end

      // Rising tick (bxclk currently low): capture. Falling tick: advance.
      SHIFT: begin
        if (tick) begin
          bxclk_d = ~bxclk_q;
          if (!bxclk_q) begin
            rx_d = {rx_q[SCAN_LEN-2:0], sample};
          end else begin
            tx_d      = {tx_q[SCAN_LEN-2:0], 1'b0};
            scan_in_d = tx_q[SCAN_LEN-2];
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            if (bit_cnt_q == BIT_LAST) begin
              data_out_d = rx_q;
              done_d     = 1'b1;
              state_d    = DONE;
            end
          end
        end
      end

      DONE: begin
        scan_in_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d input regardless of statement order.
  // NOTE: the wide shift and capture registers are reset too; scan_data_out
  // must read 0 after any reset, including one that aborts a run.
  always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      half_q     <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      bxclk_q    <= 1'b0;
      scan_in_q  <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      half_q     <= half_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      bxclk_q    <= bxclk_d;
      scan_in_q  <= scan_in_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.scan_data_out = data_out_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.fw_bxclk      = bxclk_q;
  assign bus.fw_scan_in    = scan_in_q;
  assign bus.fw_scan_load  = load_q;

endmodule
